// File: rtl/regfile_write_sequencer_if.sv
// Request/fill handshake and register-file write port bundle for regfile_write_sequencer.
// The sequencer (slave) consumes requests and drives the register file write port.
interface regfile_write_sequencer_if #(
    parameter int W     = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_addr;
    logic [W-1:0]  req_data;
    logic          fill_req;
    logic [W-1:0]  fill_value;
    logic          fill_busy;
    logic [CW-1:0] pending_count;
    logic [W-1:0]  data;
    logic [2:0]    destination_select;
    logic          write_enable;

    modport master (
        output req_valid, req_addr, req_data, fill_req, fill_value,
        input  req_ready, fill_busy, pending_count, data, destination_select, write_enable
    );

    modport slave (
        input  req_valid, req_addr, req_data, fill_req, fill_value,
        output req_ready, fill_busy, pending_count, data, destination_select, write_enable
    );
endinterface

// File: rtl/regfile_write_sequencer.sv
// Write-side front end for the 8-entry register file: request FIFO plus one write per cycle.
// Define WB_FILL_EN to add the fill sequencer that writes one value to all 8 registers.
module regfile_write_sequencer #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input logic                     clk,
    input logic                     rst,
    regfile_write_sequencer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t        state, next_state;
    logic [2:0]    addr_mem [DEPTH];
    logic [W-1:0]  data_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [W-1:0]  data_q, data_n;
    logic [2:0]    dest_q, dest_n;
    logic          we_q, we_n;
    logic          push, pop;
`ifdef WB_FILL_EN
    logic [2:0]    fill_cnt, fill_cnt_n;
    logic [W-1:0]  fill_val, fill_val_n;
`endif

    // Ready comes from the registered count only, so a pop while full cannot raise it early.
    assign bus.req_ready = (count < CW'(DEPTH));
    assign push          = bus.req_valid && bus.req_ready;

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        data_n     = data_q;
        dest_n     = dest_q;
        we_n       = 1'b0;
`ifdef WB_FILL_EN
        fill_cnt_n = fill_cnt;
        fill_val_n = fill_val;
        case (state)
            IDLE: begin
                if (bus.fill_req) begin
                    next_state = FILL;
                    fill_cnt_n = 3'd0;
                    fill_val_n = bus.fill_value;
                end else if (count != '0) begin
                    pop    = 1'b1;
                    data_n = data_mem[rd_ptr];
                    dest_n = addr_mem[rd_ptr];
                    we_n   = 1'b1;
                end
            end
            FILL: begin
                data_n     = fill_val;
                dest_n     = fill_cnt;
                we_n       = 1'b1;
                fill_cnt_n = fill_cnt + 3'd1;
                if (fill_cnt == 3'd7) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
`else
        if (count != '0) begin
            pop    = 1'b1;
            data_n = data_mem[rd_ptr];
            dest_n = addr_mem[rd_ptr];
            we_n   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            data_q <= '0;
            dest_q <= '0;
            we_q   <= 1'b0;
`ifdef WB_FILL_EN
            fill_cnt <= '0;
            fill_val <= '0;
`endif
        end else begin
            state  <= next_state;
            data_q <= data_n;
            dest_q <= dest_n;
            we_q   <= we_n;
`ifdef WB_FILL_EN
            fill_cnt <= fill_cnt_n;
            fill_val <= fill_val_n;
`endif
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= bus.req_addr;
            data_mem[wr_ptr] <= bus.req_data;
        end
    end

    assign bus.pending_count      = count;
    assign bus.data               = data_q;
    assign bus.destination_select = dest_q;
    assign bus.write_enable       = we_q;
`ifdef WB_FILL_EN
    assign bus.fill_busy = (state == FILL);
`else
    assign bus.fill_busy = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Self-checking bench for regfile_write_sequencer against a queue-based write model.
// Fill scenarios run when WB_FILL_EN is defined; otherwise fill inputs must be ignored.
module tb_regfile_write_sequencer;
    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WB_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]   addr;
        logic [W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_write_sequencer_if #(.W(W), .DEPTH(DEPTH)) bus ();
    regfile_write_sequencer #(.W(W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    wr_t          m_q [$];
    int           m_fill_left = 0;
    logic [W-1:0] m_fill_val  = '0;
    logic         m_we        = 1'b0;
    logic [2:0]   m_addr      = '0;
    logic [W-1:0] m_data      = '0;
    int           tests_run    = 0;
    int           tests_failed = 0;

    // Advance one edge; the model applies the same edge's inputs using queue semantics.
    task automatic tick();
        logic         v, fr, r, accept;
        logic [2:0]   a;
        logic [W-1:0] d, fv;
        wr_t          e;
        @(posedge clk);
        v = bus.req_valid; a = bus.req_addr; d = bus.req_data;
        fr = bus.fill_req; fv = bus.fill_value; r = rst;
        if (r) begin
            m_q.delete();
            m_fill_left = 0;
            m_we = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            accept = v && (m_q.size() < DEPTH);
            m_we = 1'b0;
            if (m_fill_left > 0) begin
                m_we = 1'b1;
                m_addr = 3'(8 - m_fill_left);
                m_data = m_fill_val;
                m_fill_left--;
            end else if (FILL_EN && fr) begin
                m_fill_left = 8;
                m_fill_val = fv;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_we = 1'b1; m_addr = e.addr; m_data = e.data;
            end
            if (accept) m_q.push_back('{addr: a, data: d});
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0;
        bus.fill_req = 1'b0; bus.fill_value = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (bus.write_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_we got %b want 0", bus.write_enable); end
        tests_run++;
        if (bus.pending_count !== CW'(0)) begin tests_failed++; $display("[TB] FAIL reset_count got %0d want 0", bus.pending_count); end
        tests_run++;
        if (bus.data !== '0 || bus.destination_select !== 3'd0) begin
            tests_failed++; $display("[TB] FAIL reset_outputs got data=%h dest=%0d want 0/0", bus.data, bus.destination_select);
        end
        tests_run++;
        if (bus.fill_busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL reset_busy_ready got busy=%b ready=%b want 0/1", bus.fill_busy, bus.req_ready);
        end
        tick();
        tests_run++;
        if (bus.write_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset_we got %b want 0", bus.write_enable); end
    endtask

    task automatic test_single();
        bus.req_valid = 1'b1; bus.req_addr = 3'd5; bus.req_data = 4'hA;
        tick();
        idle_inputs();
        tests_run++;
        if (bus.pending_count !== CW'(1)) begin tests_failed++; $display("[TB] FAIL single_count got %0d want 1", bus.pending_count); end
        tick();
        tests_run++;
        if (bus.write_enable !== 1'b1 || bus.destination_select !== 3'd5 || bus.data !== 4'hA) begin
            tests_failed++;
            $display("[TB] FAIL single_write got we=%b dest=%0d data=%h want 1/5/a", bus.write_enable, bus.destination_select, bus.data);
        end
        tests_run++;
        if (bus.pending_count !== CW'(0)) begin tests_failed++; $display("[TB] FAIL single_drain got %0d want 0", bus.pending_count); end
        tick();
        tests_run++;
        if (bus.write_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_one_pulse got %b want 0", bus.write_enable); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            if (i < 10) begin
                bus.req_valid = 1'b1; bus.req_addr = 3'(i % 8); bus.req_data = W'($urandom);
                tests_run++;
                if (bus.req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ready[%0d] got %b want 1", i, bus.req_ready); end
            end else begin
                idle_inputs();
            end
            tick();
            tests_run++;
            if (bus.write_enable !== ((i >= 1 && i <= 10) ? 1'b1 : 1'b0)) begin
                tests_failed++; $display("[TB] FAIL b2b_we[%0d] got %b", i, bus.write_enable);
            end
            tests_run++;
            if (m_we && (bus.destination_select !== 3'((i - 1) % 8) || bus.data !== m_data)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_write[%0d] got %0d/%h want %0d/%h", i, bus.destination_select, bus.data, (i - 1) % 8, m_data);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            bus.req_valid  = ($urandom_range(0, 3) != 0);
            bus.req_addr   = 3'($urandom);
            bus.req_data   = W'($urandom);
            bus.fill_req   = ($urandom_range(0, 19) == 0);
            bus.fill_value = W'($urandom);
            tick();
            tests_run++;
            if (bus.write_enable !== m_we) begin tests_failed++; $display("[TB] FAIL rand_we[%0d] got %b want %b", i, bus.write_enable, m_we); end
            tests_run++;
            if (m_we && (bus.destination_select !== m_addr || bus.data !== m_data)) begin
                tests_failed++;
                $display("[TB] FAIL rand_write[%0d] got %0d/%h want %0d/%h", i, bus.destination_select, bus.data, m_addr, m_data);
            end
            tests_run++;
            if (bus.pending_count !== CW'(m_q.size()) || bus.req_ready !== (m_q.size() < DEPTH)) begin
                tests_failed++;
                $display("[TB] FAIL rand_count[%0d] got %0d/%b want %0d", i, bus.pending_count, bus.req_ready, m_q.size());
            end
            tests_run++;
            if (bus.fill_busy !== (m_fill_left > 0)) begin
                tests_failed++; $display("[TB] FAIL rand_busy[%0d] got %b want %b", i, bus.fill_busy, m_fill_left > 0);
            end
        end
        idle_inputs();
        for (int i = 0; i < 14; i++) tick();
    endtask

`ifdef WB_FILL_EN
    task automatic test_fill();
        bus.fill_req = 1'b1; bus.fill_value = 4'h3;
        tick();
        idle_inputs();
        tests_run++;
        if (bus.fill_busy !== 1'b1 || bus.write_enable !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL fill_start got busy=%b we=%b want 1/0", bus.fill_busy, bus.write_enable);
        end
        for (int i = 0; i < 8; i++) begin
            bus.fill_req = (i == 2); bus.fill_value = 4'h9;
            tick();
            tests_run++;
            if (bus.write_enable !== 1'b1 || bus.destination_select !== 3'(i) || bus.data !== 4'h3) begin
                tests_failed++;
                $display("[TB] FAIL fill_write[%0d] got %b/%0d/%h want 1/%0d/3", i, bus.write_enable, bus.destination_select, bus.data, i);
            end
            tests_run++;
            if (bus.fill_busy !== (i < 7)) begin tests_failed++; $display("[TB] FAIL fill_busy[%0d] got %b", i, bus.fill_busy); end
        end
        idle_inputs();
        tick();
        tests_run++;
        if (bus.write_enable !== 1'b0 || bus.fill_busy !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL fill_refill got we=%b busy=%b want 0/0", bus.write_enable, bus.fill_busy);
        end
    endtask

    task automatic test_fill_queue();
        wr_t exp [4];
        bus.fill_req = 1'b1; bus.fill_value = 4'h6;
        tick();
        idle_inputs();
        for (int j = 0; j < 4; j++) begin
            exp[j] = '{addr: 3'($urandom), data: W'($urandom)};
            bus.req_valid = 1'b1; bus.req_addr = exp[j].addr; bus.req_data = exp[j].data;
            tick();
        end
        idle_inputs();
        tests_run++;
        if (bus.req_ready !== 1'b0 || bus.pending_count !== CW'(4)) begin
            tests_failed++; $display("[TB] FAIL fq_full got ready=%b count=%0d want 0/4", bus.req_ready, bus.pending_count);
        end
        for (int j = 0; j < 4; j++) tick();
        for (int j = 0; j < 4; j++) begin
            tick();
            tests_run++;
            if (bus.write_enable !== 1'b1 || bus.destination_select !== exp[j].addr || bus.data !== exp[j].data) begin
                tests_failed++;
                $display("[TB] FAIL fq_drain[%0d] got %b/%0d/%h want 1/%0d/%h", j, bus.write_enable, bus.destination_select, bus.data, exp[j].addr, exp[j].data);
            end
        end
        tick();
    endtask

    task automatic test_fill_reset();
        bus.req_valid = 1'b1; bus.req_addr = 3'd2; bus.req_data = 4'h5;
        bus.fill_req = 1'b1; bus.fill_value = 4'hC;
        tick();
        idle_inputs();
        for (int j = 0; j < 3; j++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (bus.write_enable !== 1'b0 || bus.fill_busy !== 1'b0 || bus.pending_count !== CW'(0)) begin
            tests_failed++;
            $display("[TB] FAIL fill_reset got we=%b busy=%b count=%0d want 0/0/0", bus.write_enable, bus.fill_busy, bus.pending_count);
        end
        tick();
        tests_run++;
        if (bus.write_enable !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_reset_after got %b want 0", bus.write_enable); end
    endtask
`else
    task automatic test_fill_ignored();
        for (int i = 0; i < 6; i++) begin
            bus.fill_req = 1'b1; bus.fill_value = W'($urandom);
            bus.req_valid = (i < 3); bus.req_addr = 3'(i + 1); bus.req_data = W'(i + 7);
            tick();
            tests_run++;
            if (bus.fill_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL nofill_busy[%0d] got %b want 0", i, bus.fill_busy); end
            tests_run++;
            if (bus.write_enable !== (i >= 1 && i <= 3)) begin
                tests_failed++; $display("[TB] FAIL nofill_we[%0d] got %b", i, bus.write_enable);
            end
            tests_run++;
            if (bus.write_enable && (bus.destination_select !== 3'(i) || bus.data !== W'(i + 6))) begin
                tests_failed++; $display("[TB] FAIL nofill_write[%0d] got %0d/%h want %0d/%h", i, bus.destination_select, bus.data, i, i + 6);
            end
        end
        idle_inputs();
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
`ifdef WB_FILL_EN
        test_fill();
        test_fill_queue();
        test_fill_reset();
`else
        test_fill_ignored();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end
endmodule
